// File: rtl/reg_spi_pkg.sv
// Shared widths, register map and payload-length table for the register SPI loader.
package reg_spi_pkg;

    localparam int DEF_CMD_W  = 4;
    localparam int DEF_DATA_W = 24;
    localparam int LEN_W      = $clog2(DEF_DATA_W + 1);

    typedef enum logic [DEF_CMD_W-1:0] {
        SKY     = 4'd0,
        FLOOR   = 4'd1,
        LEAK    = 4'd2,
        OTHER   = 4'd3,
        VSHIFT  = 4'd4,
        VINF    = 4'd5,
        MAPD    = 4'd6,
        TEXADD0 = 4'd7
    } reg_addr_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA,
        ST_WAIT
    } state_e;

    // Payload length in bits for each command; zero marks an unused address.
    function automatic logic [LEN_W-1:0] payload_len(input logic [DEF_CMD_W-1:0] cmd);
        case (cmd)
            SKY:     payload_len = LEN_W'(6);
            FLOOR:   payload_len = LEN_W'(6);
            LEAK:    payload_len = LEN_W'(6);
            OTHER:   payload_len = LEN_W'(12);
            VSHIFT:  payload_len = LEN_W'(6);
            VINF:    payload_len = LEN_W'(1);
            MAPD:    payload_len = LEN_W'(16);
            TEXADD0: payload_len = LEN_W'(24);
            default: payload_len = '0;
        endcase
    endfunction

endpackage

// File: rtl/reg_spi_loader_if.sv
// Register-write port from the loader into the core register file.
interface reg_spi_loader_if #(
    parameter int CMD_W  = 4,
    parameter int DATA_W = 24
);
    logic              wr_valid;
    logic [CMD_W-1:0]  wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (output wr_valid, output wr_addr, output wr_data);
    modport slave  (input  wr_valid, input  wr_addr, input  wr_data);
endinterface

// File: rtl/reg_spi_loader_sync_edge.sv
// Synchroniser chain for one asynchronous line plus registered rise/fall pulses.
module sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_rise,
    output logic o_fall
);
    logic [STAGES-1:0] r_sync;
    logic              r_prev;
    logic              r_rise;
    logic              r_fall;

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync <= {STAGES{RESET_VAL}};
            r_prev <= RESET_VAL;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
            r_prev <= r_sync[STAGES-1];
            r_rise <= r_sync[STAGES-1] & ~r_prev;
            r_fall <= ~r_sync[STAGES-1] & r_prev;
        end
    end

    assign o_rise = r_rise;
    assign o_fall = r_fall;
endmodule

// File: rtl/reg_spi_loader.sv
// SPI register-write deframer: synchronises the LA-driven SPI lines, decodes <cmd><payload>
// frames and holds one write until the core's frame-boundary commit strobe.
module reg_spi_loader
    import reg_spi_pkg::*;
#(
    parameter int CMD_W       = DEF_CMD_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_reg_csb,
    input  logic             i_reg_sclk,
    input  logic             i_reg_mosi,
    input  logic             i_commit,
    reg_spi_loader_if.master wr,
    output logic             o_pending,
    output logic             o_overrun,
    output logic [3:0]       o_err_count
);
    localparam int FLUSH_CYCLES = SYNC_STAGES + 2;
    localparam int FLUSH_W      = $clog2(FLUSH_CYCLES + 1);

    logic w_csb_rise_raw, w_csb_fall_raw, w_sclk_rise_raw, w_sclk_fall_unused;
    logic w_csb_rise, w_csb_fall, w_sclk_rise, w_mosi, w_ready;

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_csb_sync (
        .i_clk(i_clk), .i_reset(i_reset), .i_d(i_reg_csb),
        .o_rise(w_csb_rise_raw), .o_fall(w_csb_fall_raw)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .i_clk(i_clk), .i_reset(i_reset), .i_d(i_reg_sclk),
        .o_rise(w_sclk_rise_raw), .o_fall(w_sclk_fall_unused)
    );

    // mosi is delayed by the chain plus the edge flop so it lines up with the sclk rise pulse.
    logic [SYNC_STAGES:0]  r_mosi_dly;
    logic [FLUSH_W-1:0]    r_flush_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_mosi_dly  <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_mosi_dly <= {r_mosi_dly[SYNC_STAGES-1:0], i_reg_mosi};
            if (!w_ready) r_flush_cnt <= r_flush_cnt + FLUSH_W'(1);
        end
    end

    // Edges ignored until the preset csb chain has flushed, so csb held low through reset is no start.
    assign w_ready     = (r_flush_cnt == FLUSH_W'(FLUSH_CYCLES));
    assign w_mosi      = r_mosi_dly[SYNC_STAGES];
    assign w_csb_rise  = w_ready & w_csb_rise_raw;
    assign w_csb_fall  = w_ready & w_csb_fall_raw;
    assign w_sclk_rise = w_ready & w_sclk_rise_raw;

    state_e             r_state, w_state_nxt;
    logic [LEN_W-1:0]   r_cnt, w_cnt_nxt;
    logic [LEN_W-1:0]   r_len, w_len_nxt;
    logic [CMD_W-1:0]   r_cmd, w_cmd_nxt, w_cmd_shift;
    logic [DATA_W-1:0]  r_data, w_data_nxt;
    logic [LEN_W-1:0]   w_len_lookup;
    logic               w_err_inc, w_load;

    assign w_cmd_shift  = {r_cmd[CMD_W-2:0], w_mosi};
    assign w_len_lookup = payload_len(w_cmd_shift);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_len   <= '0;
            r_cmd   <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_len   <= w_len_nxt;
            r_cmd   <= w_cmd_nxt;
            r_data  <= w_data_nxt;
        end
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_len_nxt   = r_len;
        w_cmd_nxt   = r_cmd;
        w_data_nxt  = r_data;
        w_err_inc   = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_csb_fall) begin
                    w_state_nxt = ST_CMD;
                    w_cnt_nxt   = '0;
                    w_cmd_nxt   = '0;
                    w_data_nxt  = '0;
                end
            end
            ST_CMD: begin
                if (w_csb_rise) begin
                    w_state_nxt = ST_IDLE;
                    w_err_inc   = 1'b1;
                end else if (w_sclk_rise) begin
                    w_cmd_nxt = w_cmd_shift;
                    w_cnt_nxt = r_cnt + LEN_W'(1);
                    if (r_cnt == LEN_W'(CMD_W - 1)) begin
                        w_cnt_nxt = '0;
                        w_len_nxt = w_len_lookup;
                        if (w_len_lookup == '0) begin
                            w_state_nxt = ST_WAIT;
                            w_err_inc   = 1'b1;
                        end else begin
                            w_state_nxt = ST_DATA;
                        end
                    end
                end
            end
            ST_DATA: begin
                if (w_csb_rise) begin
                    w_state_nxt = ST_IDLE;
                    if (r_cnt == r_len) w_load = 1'b1;
                    else                w_err_inc = 1'b1;
                end else if (w_sclk_rise) begin
                    if (r_cnt == r_len) begin
                        w_state_nxt = ST_WAIT;
                        w_err_inc   = 1'b1;
                    end else begin
                        w_data_nxt = {r_data[DATA_W-2:0], w_mosi};
                        w_cnt_nxt  = r_cnt + LEN_W'(1);
                    end
                end
            end
            ST_WAIT: begin
                if (w_csb_rise) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    logic              r_pending, r_overrun, r_wr_valid;
    logic [3:0]        r_err_count;
    logic [CMD_W-1:0]  r_pend_addr, r_wr_addr;
    logic [DATA_W-1:0] r_pend_data, r_wr_data;
    logic              w_fire;

    assign w_fire = i_commit & r_pending;

    // A load and a commit in the same cycle emit the old write and keep the new one pending.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pending   <= 1'b0;
            r_overrun   <= 1'b0;
            r_wr_valid  <= 1'b0;
            r_err_count <= '0;
            r_pend_addr <= '0;
            r_pend_data <= '0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
        end else begin
            r_wr_valid <= w_fire;
            if (w_fire) begin
                r_wr_addr <= r_pend_addr;
                r_wr_data <= r_pend_data;
            end
            if (w_load) begin
                r_pending   <= 1'b1;
                r_pend_addr <= r_cmd;
                r_pend_data <= r_data;
                if (r_pending && !i_commit) r_overrun <= 1'b1;
            end else if (w_fire) begin
                r_pending <= 1'b0;
            end
            if (w_err_inc && r_err_count != 4'hF) r_err_count <= r_err_count + 4'd1;
        end
    end

    assign wr.wr_valid  = r_wr_valid;
    assign wr.wr_addr   = r_wr_addr;
    assign wr.wr_data   = r_wr_data;
    assign o_pending    = r_pending;
    assign o_overrun    = r_overrun;
    assign o_err_count  = r_err_count;
endmodule

// File: tb/tb_reg_spi_loader.sv
// Directed and randomised SPI frames against a frame-level model of the loader.
module tb_reg_spi_loader;
    import reg_spi_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, csb, sclk, mosi, commit;
    logic       pending, overrun;
    logic [3:0] err_count;

    reg_spi_loader_if #(.CMD_W(4), .DATA_W(24)) wr_if ();

    reg_spi_loader #(.CMD_W(4), .DATA_W(24), .SYNC_STAGES(2)) dut (
        .i_clk(clk), .i_reset(reset), .i_reg_csb(csb), .i_reg_sclk(sclk),
        .i_reg_mosi(mosi), .i_commit(commit), .wr(wr_if),
        .o_pending(pending), .o_overrun(overrun), .o_err_count(err_count)
    );

    int checks = 0;
    int errors = 0;

    // Frame-level model: what the register file should eventually see.
    logic        m_pending, m_overrun;
    int          m_err;
    logic [3:0]  m_addr, m_last_addr;
    logic [23:0] m_data, m_last_data;
    int          len_tab [16] = '{6, 6, 6, 12, 6, 1, 16, 24, 0, 0, 0, 0, 0, 0, 0, 0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model_reset();
        m_pending   = 1'b0;
        m_overrun   = 1'b0;
        m_err       = 0;
        m_addr      = '0;
        m_data      = '0;
        m_last_addr = '0;
        m_last_data = '0;
    endtask

    task automatic model_frame(input int cmd, input int nbits, input logic [31:0] v);
        int len;
        len = len_tab[cmd];
        if (len == 0 || nbits != len) begin
            if (m_err < 15) m_err++;
        end else begin
            if (m_pending) m_overrun = 1'b1;
            m_pending = 1'b1;
            m_addr    = 4'(cmd);
            m_data    = 24'(v & ((32'd1 << len) - 32'd1));
        end
    endtask

    task automatic send_bits(input logic [31:0] v, input int n, input int half);
        for (int i = n - 1; i >= 0; i--) begin
            mosi = v[i];
            tick(half);
            sclk = 1'b1;
            tick(half);
            sclk = 1'b0;
        end
    endtask

    task automatic spi_frame(input int cmd, input int nbits, input logic [31:0] v, input int half);
        csb = 1'b0;
        tick(half);
        send_bits(32'(cmd), 4, half);
        send_bits(v, nbits, half);
        tick(half);
        csb = 1'b1;
        model_frame(cmd, nbits, v);
        tick(8);
    endtask

    task automatic check_state(input string tag);
        check({tag, ":pending"}, 32'(pending), 32'(m_pending));
        check({tag, ":overrun"}, 32'(overrun), 32'(m_overrun));
        check({tag, ":err"}, 32'(err_count), 32'(m_err));
        check({tag, ":valid"}, 32'(wr_if.wr_valid), 32'd0);
        check({tag, ":addr"}, 32'(wr_if.wr_addr), 32'(m_last_addr));
        check({tag, ":data"}, 32'(wr_if.wr_data), 32'(m_last_data));
    endtask

    task automatic do_commit(input string tag);
        logic exp_valid;
        commit = 1'b1;
        tick(1);
        commit = 1'b0;
        exp_valid = m_pending;
        if (m_pending) begin
            m_last_addr = m_addr;
            m_last_data = m_data;
            m_pending   = 1'b0;
        end
        check({tag, ":commit_valid"}, 32'(wr_if.wr_valid), 32'(exp_valid));
        check({tag, ":commit_addr"}, 32'(wr_if.wr_addr), 32'(m_last_addr));
        check({tag, ":commit_data"}, 32'(wr_if.wr_data), 32'(m_last_data));
        check({tag, ":commit_pending"}, 32'(pending), 32'(m_pending));
        tick(1);
        check({tag, ":valid_drop"}, 32'(wr_if.wr_valid), 32'd0);
    endtask

    initial begin
        int cmd, nbits, half;
        logic [31:0] v;

        reset = 1'b1; csb = 1'b1; sclk = 1'b0; mosi = 1'b0; commit = 1'b0;
        model_reset();
        tick(3);
        reset = 1'b0;
        tick(6);
        check_state("reset");

        // SKY 6'h2A, with pin-to-pending latency of SYNC_STAGES+2 cycles.
        csb = 1'b0;
        tick(3);
        send_bits(32'd0, 4, 3);
        send_bits(32'h2A, 6, 3);
        tick(3);
        csb = 1'b1;
        model_frame(0, 6, 32'h2A);
        tick(3);
        check("sky:latency_early", 32'(pending), 32'd0);
        tick(1);
        check("sky:latency", 32'(pending), 32'd1);
        tick(10);
        check_state("sky_hold");
        do_commit("sky");
        check("sky:data_abs", 32'(wr_if.wr_data), 32'h2A);

        // TEXADD0 full 24-bit payload at the fastest legal sclk.
        spi_frame(7, 24, 32'hABCDEF, 2);
        check_state("texadd0");
        do_commit("texadd0");
        check("texadd0:data_abs", 32'(wr_if.wr_data), 32'hABCDEF);

        // Short payloads are discarded.
        spi_frame(1, 5, 32'h1F, 3);
        check_state("floor_short");
        spi_frame(2, 7, 32'h55, 3);
        check_state("leak_long");

        // Two writes before a commit: only the second is emitted.
        spi_frame(0, 6, 32'd1, 3);
        spi_frame(1, 6, 32'd3, 3);
        check_state("overrun");
        do_commit("overrun");
        do_commit("idle_commit");

        for (int it = 0; it < 14; it++) begin
            cmd = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8, 15)) : int'($urandom_range(0, 7));
            nbits = ($urandom_range(0, 1) == 0) ? len_tab[cmd] : int'($urandom_range(0, len_tab[cmd] + 2));
            half = int'($urandom_range(2, 4));
            v = $urandom;
            spi_frame(cmd, nbits, v, half);
            check_state($sformatf("rand%0d", it));
            if ($urandom_range(0, 1) == 1) do_commit($sformatf("rand%0d", it));
        end

        // Reset in the middle of a MAPD payload; the tail bits must not start a frame.
        csb = 1'b0;
        tick(3);
        send_bits(32'd6, 4, 3);
        send_bits(32'hBEEF, 8, 3);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        model_reset();
        send_bits(32'h00EF, 8, 3);
        tick(3);
        csb = 1'b1;
        tick(8);
        check_state("mid_reset");
        spi_frame(6, 16, 32'h1234, 3);
        check_state("after_reset");
        do_commit("after_reset");

        // Load and commit landing in the same cycle.
        spi_frame(0, 6, 32'h15, 3);
        csb = 1'b0;
        tick(3);
        send_bits(32'd5, 4, 3);
        send_bits(32'd1, 1, 3);
        tick(3);
        csb = 1'b1;
        tick(3);
        commit = 1'b1;
        tick(1);
        commit = 1'b0;
        check("same_cycle:valid", 32'(wr_if.wr_valid), 32'd1);
        check("same_cycle:addr", 32'(wr_if.wr_addr), 32'd0);
        check("same_cycle:data", 32'(wr_if.wr_data), 32'h15);
        check("same_cycle:pending", 32'(pending), 32'd1);
        check("same_cycle:overrun", 32'(overrun), 32'd0);
        m_last_addr = 4'd0;
        m_last_data = 24'h15;
        m_addr      = 4'd5;
        m_data      = 24'd1;
        tick(1);
        check_state("same_cycle_after");
        do_commit("same_cycle_second");

        // Invalid command errors saturate at 15.
        spi_frame(9, 5, 32'h1F, 3);
        check("sat:first", 32'(err_count), 32'd1);
        for (int k = 0; k < 15; k++) spi_frame(9, 5, 32'h1F, 2);
        check_state("saturate");
        check("sat:abs", 32'(err_count), 32'd15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
